// File: rtl/key_stim_sequencer.sv
// Key-press stimulus generator: drives an active-low key bus with a repeated release/press pattern.
// Optional KEY_SEQ_WALK_EN: each iteration presses one masked key, walking upward through the mask.
module key_stim_sequencer #(
  parameter int NUM_KEYS = 4,
  parameter int CNT_W    = 16,
  parameter int REP_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    hold_cycles,
  input  logic [CNT_W-1:0]    press_cycles,
  input  logic [REP_W-1:0]    repeat_count,
  input  logic [NUM_KEYS-1:0] key_mask,
  output logic [NUM_KEYS-1:0] key_n,
  output logic                busy,
  output logic                done,
  output logic [REP_W-1:0]    iter
);

  typedef enum logic [1:0] {IDLE, RELEASE, PRESS, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [CNT_W-1:0]    hold_m1, hold_m1_next;
  logic [CNT_W-1:0]    press_m1, press_m1_next;
  logic [REP_W-1:0]    rep, rep_next;
  logic [REP_W-1:0]    iter_next;
  logic [NUM_KEYS-1:0] mask, mask_next;
  logic [NUM_KEYS-1:0] press_set;
  logic [NUM_KEYS-1:0] key_n_next;
  logic                busy_next, done_next;

`ifdef KEY_SEQ_WALK_EN
  localparam int PTR_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [PTR_W-1:0] ptr, ptr_next;

  // First set bit strictly above 'from', wrapping; from = NUM_KEYS-1 yields the lowest set bit.
  function automatic logic [PTR_W-1:0] next_set(input logic [NUM_KEYS-1:0] m, input int from);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int s = NUM_KEYS; s >= 1; s--) begin
      int idx;
      idx = (from + s) % NUM_KEYS;
      if (m[idx]) r = PTR_W'(idx);
    end
    return r;
  endfunction

  assign press_set = mask & (NUM_KEYS'(1) << ptr);
`else
  assign press_set = mask;
`endif

  // NOTE: every variable gets a default first so no path through the case leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    hold_m1_next  = hold_m1;
    press_m1_next = press_m1;
    rep_next      = rep;
    mask_next     = mask;
    iter_next     = iter;
`ifdef KEY_SEQ_WALK_EN
    ptr_next      = ptr;
`endif

    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next    = RELEASE;
            hold_m1_next  = (hold_cycles  == '0) ? '0 : hold_cycles  - CNT_W'(1);
            press_m1_next = (press_cycles == '0) ? '0 : press_cycles - CNT_W'(1);
            cnt_next      = hold_m1_next;
            rep_next      = repeat_count;
            mask_next     = key_mask;
            iter_next     = '0;
`ifdef KEY_SEQ_WALK_EN
            ptr_next      = next_set(key_mask, NUM_KEYS - 1);
`endif
          end
        end
        RELEASE: begin
          if (cnt == '0) begin
            state_next = PRESS;
            cnt_next   = press_m1;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            iter_next = iter + REP_W'(1);
            // Repeat count of zero never matches, so the loop runs until abort.
            if (rep != '0 && iter_next == rep) begin
              state_next = DONE;
            end else begin
              state_next = RELEASE;
              cnt_next   = hold_m1;
`ifdef KEY_SEQ_WALK_EN
              ptr_next   = next_set(mask, int'(ptr));
`endif
            end
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state_next = IDLE;
        end
      endcase
    end

    // Outputs are decoded from the next state so they can be registered with no extra latency.
    busy_next  = (state_next == RELEASE) || (state_next == PRESS);
    done_next  = (state_next == DONE);
    key_n_next = (state_next == PRESS) ? ~press_set : '1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      iter     <= '0;
      key_n    <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      iter     <= iter_next;
      key_n    <= key_n_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // NOTE: latched parameters are left unreset; they are always reloaded on start before use.
  always_ff @(posedge clk) begin
    hold_m1  <= hold_m1_next;
    press_m1 <= press_m1_next;
    rep      <= rep_next;
    mask     <= mask_next;
  end

`ifdef KEY_SEQ_WALK_EN
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_next;
  end
`endif

endmodule

// File: doc/key_stim_sequencer.md
# key_stim_sequencer

Synthesisable key-press stimulus generator that drives an active-low push-button bus with a programmable release/press pattern, repeated a fixed or unbounded number of times. It extends the fixed "release for N cycles, press for one cycle, three times" pattern to configurable phase lengths, repeat count, key count and key mask, and adds abort and done handshakes. It sits between a bench or on-board controller and the KEY inputs of the unit under test.

## Interface
- NUM_KEYS, 4, width of key bus.
- CNT_W, 16, width of phase-length inputs and counters.
- REP_W, 8, width of repeat count and iteration counter.

- clk  in  1  system clock (CLOCK_50 domain); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  terminate sequence; sampled in every state.
- hold_cycles  in  CNT_W  release-phase length, latched on start.
- press_cycles  in  CNT_W  press-phase length, latched on start.
- repeat_count  in  REP_W  iterations; 0 = continuous; latched on start.
- key_mask  in  NUM_KEYS  keys to press, latched on start.
- key_n  out  NUM_KEYS  active-low key drive; 1 = released.
- busy  out  1  high while a sequence runs.
- done  out  1  one-cycle pulse on normal completion.
- iter  out  REP_W  completed-iteration count.

## Operation
- States: IDLE, RELEASE, PRESS, DONE.
- IDLE: key_n all 1, busy 0. start=1 and abort=0 latch all parameters, clear iter, go to RELEASE.
- RELEASE: key_n all 1 for H = max(hold_cycles,1) cycles, then go to PRESS.
- PRESS: key_n = ~press_set for P = max(press_cycles,1) cycles. At the end of the phase, iter increments.
  - Go to DONE if the new iter equals R (R ≠ 0).
  - Otherwise go to RELEASE.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE. iter holds R until the next start.
- Continuous (R=0): loop RELEASE/PRESS until abort. iter wraps modulo 2^REP_W.
- abort=1 in any state: next cycle IDLE, key_n all 1, busy 0, no done pulse, iter keeps its value. abort together with start in IDLE stays IDLE.
- start while busy is ignored. Parameter changes while busy have no effect.
- press_set = latched key_mask (see Configuration). Mask 0 runs normal timing with no key driven low.
- Counters are CNT_W bits and count down from H-1 or P-1. There is no overflow path.

## Timing
- Reset values: key_n all 1, busy 0, done 0, iter 0, state IDLE.
- All outputs are registered.
- Start sampled at cycle 0:
  - busy high for cycles 1..R·(H+P).
  - Iteration k (1-based) release: cycles (k-1)(H+P)+1 .. (k-1)(H+P)+H.
  - Iteration k press: the next P cycles.
- done is high at cycle R·(H+P)+1. busy is 0 in that cycle.
- Earliest accepted restart is the cycle after done.
- rst mid-sequence: reset values in the cycle after rst is sampled. No done pulse.

## Configuration
- KEY_SEQ_WALK_EN defined: each iteration presses exactly one key. It walks through the set bits of the latched mask, starting at the lowest set bit, ascending, and wrapping to the lowest set bit.
- KEY_SEQ_WALK_EN undefined: every iteration presses all masked keys simultaneously. No walk pointer logic is synthesised.

## Test plan
- Baseline, H=19210, P=1, R=3, mask=4'b0001:
  - key_n[0]=0 only at cycles 19211, 38422 and 57633.
  - done at cycle 57634; iter=3.
  - key_n[3:1] stay 1 throughout.
- Zero lengths, H=0, P=0, R=2, mask=4'b1111:
  - Release at cycles 1 and 3; key_n=4'b0000 at cycles 2 and 4.
  - done at cycle 5.
- Continuous mode, R=0, H=4, P=2, mask=4'b0010:
  - Pulses repeat every 6 cycles.
  - abort at cycle 20 gives key_n=4'b1111 and busy=0 at cycle 21, with no done pulse.
- Mid-sequence disturbance, during a PRESS phase:
  - start while busy is ignored; the pattern is unchanged.
  - rst asserted for one cycle gives all outputs at reset values the next cycle.
- Walk mode (KEY_SEQ_WALK_EN), mask=4'b1010, R=3, H=2, P=1:
  - Presses key_n=4'b1101, then 4'b0111, then 4'b1101.
  - Without the macro, all three presses are 4'b0101.
